// File: rtl/solomon_pkg.sv
// Shared types and address map for the Solomon ROM download path.
package solomon_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, FAIL} state_e;

  localparam logic [24:0] TOTAL_DEF = 25'h30000;

  localparam logic [24:0] SND_BASE  = 25'h0C000;
  localparam logic [24:0] FG_BASE   = 25'h10000;
  localparam logic [24:0] BG_BASE   = 25'h18000;
  localparam logic [24:0] SPR_BASE  = 25'h20000;
  localparam logic [24:0] ROM_LIMIT = 25'h30000;

  localparam logic [2:0] RGN_MAIN = 3'd0;
  localparam logic [2:0] RGN_SND  = 3'd1;
  localparam logic [2:0] RGN_FG   = 3'd2;
  localparam logic [2:0] RGN_BG   = 3'd3;
  localparam logic [2:0] RGN_SPR  = 3'd4;
  localparam logic [2:0] RGN_OOR  = 3'd7;

endpackage

// File: rtl/rom_region_dec.sv
// Combinational map from a download byte address to its ROM region code.
import solomon_pkg::*;

module rom_region_dec (
  input  logic [24:0] addr,
  output logic [2:0]  region
);

  always_comb begin
    region = RGN_OOR;
    if      (addr < SND_BASE)  region = RGN_MAIN;
    else if (addr < FG_BASE)   region = RGN_SND;
    else if (addr < BG_BASE)   region = RGN_FG;
    else if (addr < SPR_BASE)  region = RGN_BG;
    else if (addr < ROM_LIMIT) region = RGN_SPR;
  end

endmodule

// File: rtl/rom_loader.sv
// Sequences an ioctl download into the core ROM port, validates it, and
// releases core reset once a complete, in-order image has settled.
import solomon_pkg::*;

module rom_loader #(
  parameter logic [24:0] TOTAL    = TOTAL_DEF,
  parameter int          HOLD_CYC = 16
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        DL,
  input  logic        DLWR,
  input  logic [24:0] DLAD,
  input  logic [7:0]  DLDT,
  output logic [24:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic [2:0]  REGION,
  output logic        CORE_RST,
  output logic        DLERR,
  output logic        DLDONE,
  output logic [7:0]  CSUM
);

  state_e      state_q, state_d;
  logic        dl_q;
  logic [24:0] count_q, count_d;
  logic [7:0]  csum_q, csum_d;
  logic        dlerr_q, dlerr_d;
  logic [7:0]  hold_q, hold_d;
  logic [24:0] romad_q, romad_d;
  logic [7:0]  romdt_q, romdt_d;
  logic        romen_q, romen_d;
  logic [2:0]  region_q, region_d;
  logic        core_rst_q, core_rst_d;
  logic        dldone_q, dldone_d;
  logic [2:0]  dec_region;
  logic        dl_rise, dl_fall;

  rom_region_dec u_dec (
    .addr   (DLAD),
    .region (dec_region)
  );

  assign dl_rise = DL & ~dl_q;
  assign dl_fall = ~DL & dl_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    csum_d   = csum_q;
    dlerr_d  = dlerr_q;
    hold_d   = hold_q;
    romad_d  = romad_q;
    romdt_d  = romdt_q;
    romen_d  = 1'b0;
    region_d = region_q;
    case (state_q)
      LOAD: begin
        if (DLWR) begin
          if (DLAD < TOTAL) begin
            romen_d  = 1'b1;
            romad_d  = DLAD;
            romdt_d  = DLDT;
            region_d = dec_region;
            count_d  = count_q + 25'd1;
            csum_d   = csum_q + DLDT;
            if (DLAD != count_q) dlerr_d = 1'b1;
          end else begin
            dlerr_d = 1'b1;
          end
        end
        // Completion is judged on the post-write values so a last byte
        // arriving with the DL fall still counts.
        if (dl_fall) begin
          state_d = (count_d == TOTAL && !dlerr_d) ? HOLD : FAIL;
          hold_d  = 8'd0;
        end
      end
      HOLD: begin
        if (hold_q == 8'(HOLD_CYC - 1)) state_d = RUN;
        else                            hold_d  = hold_q + 8'd1;
      end
      default: ;
    endcase
    if (dl_rise) begin
      state_d = LOAD;
      count_d = '0;
      csum_d  = '0;
      dlerr_d = 1'b0;
    end
    core_rst_d = (state_d != RUN);
    dldone_d   = (state_d == RUN);
  end

  // dl_q resets high so a DL still asserted across RESET is not seen as a
  // new rise; the host must drop and re-raise DL to restart.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      dl_q       <= 1'b1;
      count_q    <= '0;
      csum_q     <= '0;
      dlerr_q    <= 1'b0;
      hold_q     <= '0;
      romad_q    <= '0;
      romdt_q    <= '0;
      romen_q    <= 1'b0;
      region_q   <= '0;
      core_rst_q <= 1'b1;
      dldone_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= DL;
      count_q    <= count_d;
      csum_q     <= csum_d;
      dlerr_q    <= dlerr_d;
      hold_q     <= hold_d;
      romad_q    <= romad_d;
      romdt_q    <= romdt_d;
      romen_q    <= romen_d;
      region_q   <= region_d;
      core_rst_q <= core_rst_d;
      dldone_q   <= dldone_d;
    end
  end

  assign ROMAD    = romad_q;
  assign ROMDT    = romdt_q;
  assign ROMEN    = romen_q;
  assign REGION   = region_q;
  assign CORE_RST = core_rst_q;
  assign DLERR    = dlerr_q;
  assign DLDONE   = dldone_q;
  assign CSUM     = csum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: a small-image instance for load/hold
// behaviour and a full-size instance for region tagging.
module tb_rom_loader;

  localparam logic [24:0] S_TOTAL = 25'h200;
  localparam int          S_HOLD  = 5;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DL = 1'b0;
  logic        DLWR = 1'b0;
  logic [24:0] DLAD = '0;
  logic [7:0]  DLDT = '0;

  logic [24:0] s_ROMAD, b_ROMAD;
  logic [7:0]  s_ROMDT, b_ROMDT, s_CSUM, b_CSUM;
  logic        s_ROMEN, b_ROMEN, s_CORE_RST, b_CORE_RST;
  logic        s_DLERR, b_DLERR, s_DLDONE, b_DLDONE;
  logic [2:0]  s_REGION, b_REGION;

  int checks = 0;
  int errors = 0;

  rom_loader #(.TOTAL(S_TOTAL), .HOLD_CYC(S_HOLD)) u_dut (
    .MCLK(MCLK), .RESET(RESET), .DL(DL), .DLWR(DLWR), .DLAD(DLAD), .DLDT(DLDT),
    .ROMAD(s_ROMAD), .ROMDT(s_ROMDT), .ROMEN(s_ROMEN), .REGION(s_REGION),
    .CORE_RST(s_CORE_RST), .DLERR(s_DLERR), .DLDONE(s_DLDONE), .CSUM(s_CSUM)
  );

  rom_loader u_big (
    .MCLK(MCLK), .RESET(RESET), .DL(DL), .DLWR(DLWR), .DLAD(DLAD), .DLDT(DLDT),
    .ROMAD(b_ROMAD), .ROMDT(b_ROMDT), .ROMEN(b_ROMEN), .REGION(b_REGION),
    .CORE_RST(b_CORE_RST), .DLERR(b_DLERR), .DLDONE(b_DLDONE), .CSUM(b_CSUM)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_region(input logic [24:0] a);
    if (a < 25'h0C000) return 3'd0;
    if (a < 25'h10000) return 3'd1;
    if (a < 25'h18000) return 3'd2;
    if (a < 25'h20000) return 3'd3;
    if (a < 25'h30000) return 3'd4;
    return 3'd7;
  endfunction

  task automatic tick(input logic dl, input logic wr, input logic [24:0] ad, input logic [7:0] dt);
    DL = dl; DLWR = wr; DLAD = ad; DLDT = dt;
    @(posedge MCLK);
    #1;
  endtask

  // Drives one full sequential image; tallies pulses and forwarding errors.
  task automatic load_image(input bit last_fall, input bit rnd,
                            output int pulses, output int bad, output logic [7:0] sum);
    logic [7:0] d;
    pulses = 0; bad = 0; sum = 8'h00;
    tick(0, 0, '0, '0);
    tick(1, 0, '0, '0);
    for (int a = 0; a < int'(S_TOTAL); a++) begin
      if (rnd && $urandom_range(3) == 0) begin
        tick(1, 0, '0, '0);
        if (s_ROMEN !== 1'b0) bad++;
      end
      d = rnd ? 8'($urandom) : a[7:0];
      sum = sum + d;
      tick((last_fall && a == int'(S_TOTAL) - 1) ? 1'b0 : 1'b1, 1'b1, 25'(a), d);
      if (s_ROMEN === 1'b1) pulses++;
      if (!(s_ROMEN === 1'b1 && s_ROMAD === 25'(a) && s_ROMDT === d)) bad++;
    end
  endtask

  task automatic test_reset();
    logic [47:0] want;
    want = {1'b1, 1'b0, 25'h0, 8'h0, 3'h0, 1'b0, 1'b0, 8'h0};
    RESET = 1'b1;
    repeat (2) @(posedge MCLK);
    #1;
    checks++;
    if ({s_CORE_RST, s_ROMEN, s_ROMAD, s_ROMDT, s_REGION, s_DLERR, s_DLDONE, s_CSUM} !== want) begin
      errors++; $display("FAIL reset_outputs got %h want %h",
        {s_CORE_RST, s_ROMEN, s_ROMAD, s_ROMDT, s_REGION, s_DLERR, s_DLDONE, s_CSUM}, want);
    end
    RESET = 1'b0;
    tick(0, 1, 25'h0, 8'h55);
    checks++;
    if ({s_CORE_RST, s_ROMEN, s_ROMAD, s_ROMDT, s_REGION, s_DLERR, s_DLDONE, s_CSUM} !== want) begin
      errors++; $display("FAIL idle_outputs got %h want %h",
        {s_CORE_RST, s_ROMEN, s_ROMAD, s_ROMDT, s_REGION, s_DLERR, s_DLDONE, s_CSUM}, want);
    end
  endtask

  task automatic test_good_load(input bit last_fall, input bit rnd);
    int p, bad, edges;
    logic [7:0] sum;
    load_image(last_fall, rnd, p, bad, sum);
    checks++;
    if (p !== int'(S_TOTAL)) begin errors++; $display("FAIL good_pulses got %0d want %0d", p, S_TOTAL); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL good_forward got %0d bad want 0", bad); end
    checks++;
    if (s_CSUM !== sum) begin errors++; $display("FAIL good_csum got %h want %h", s_CSUM, sum); end
    if (!rnd) begin
      checks++;
      if (s_CSUM !== 8'h00) begin errors++; $display("FAIL pattern_csum got %h want 00", s_CSUM); end
    end
    checks++;
    if (s_DLERR !== 1'b0) begin errors++; $display("FAIL good_dlerr got %b want 0", s_DLERR); end
    if (last_fall) edges = 1;
    else begin tick(0, 0, '0, '0); edges = 1; end
    while (s_CORE_RST === 1'b1 && edges < 40) begin
      tick(0, 0, '0, '0);
      edges++;
    end
    checks++;
    if (edges !== S_HOLD + 1) begin errors++; $display("FAIL hold_len got %0d want %0d", edges, S_HOLD + 1); end
    checks++;
    if (s_DLDONE !== 1'b1 || s_CORE_RST !== 1'b0) begin
      errors++; $display("FAIL run_state got dldone %b core_rst %b want 1 0", s_DLDONE, s_CORE_RST);
    end
  endtask

  task automatic test_outside_load();
    logic [7:0] c0;
    c0 = s_CSUM;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 25'(i), 8'($urandom));
      checks++;
      if (s_ROMEN !== 1'b0 || s_CSUM !== c0 || s_CORE_RST !== 1'b0 || s_DLDONE !== 1'b1) begin
        errors++; $display("FAIL outside_load got romen %b csum %h rst %b done %b want 0 %h 0 1",
          s_ROMEN, s_CSUM, s_CORE_RST, s_DLDONE, c0);
      end
    end
  endtask

  task automatic test_reload_reset();
    logic [7:0] sum;
    tick(1, 0, '0, '0);
    checks++;
    if (s_CORE_RST !== 1'b1 || s_CSUM !== 8'h00 || s_DLDONE !== 1'b0) begin
      errors++; $display("FAIL reload got rst %b csum %h done %b want 1 00 0", s_CORE_RST, s_CSUM, s_DLDONE);
    end
    sum = 8'h00;
    for (int a = 0; a < 10; a++) begin
      logic [7:0] d;
      d = 8'($urandom);
      sum = sum + d;
      tick(1, 1, 25'(a), d);
    end
    checks++;
    if (s_CSUM !== sum) begin errors++; $display("FAIL partial_csum got %h want %h", s_CSUM, sum); end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({s_CORE_RST, s_ROMEN, s_ROMAD, s_ROMDT, s_REGION, s_DLERR, s_DLDONE, s_CSUM} !==
        {1'b1, 1'b0, 25'h0, 8'h0, 3'h0, 1'b0, 1'b0, 8'h0}) begin
      errors++; $display("FAIL async_reset got %h want all clear with core_rst",
        {s_CORE_RST, s_ROMEN, s_ROMAD, s_ROMDT, s_REGION, s_DLERR, s_DLDONE, s_CSUM});
    end
    @(posedge MCLK);
    #1 RESET = 1'b0;
    for (int a = 10; a < 14; a++) begin
      tick(1, 1, 25'(a), 8'hA5);
      checks++;
      if (s_ROMEN !== 1'b0 || s_CORE_RST !== 1'b1 || s_CSUM !== 8'h00) begin
        errors++; $display("FAIL no_resume got romen %b rst %b csum %h want 0 1 00", s_ROMEN, s_CORE_RST, s_CSUM);
      end
    end
    tick(0, 0, '0, '0);
  endtask

  task automatic test_overrun();
    int p, bad, badrun;
    logic [7:0] sum;
    load_image(0, 1, p, bad, sum);
    tick(1, 1, S_TOTAL, 8'h5A);
    checks++;
    if (s_ROMEN !== 1'b0 || s_DLERR !== 1'b1 || s_CSUM !== sum) begin
      errors++; $display("FAIL overrun_write got romen %b err %b csum %h want 0 1 %h", s_ROMEN, s_DLERR, s_CSUM, sum);
    end
    tick(0, 0, '0, '0);
    badrun = 0;
    for (int i = 0; i < S_HOLD + 4; i++) begin
      tick(0, 0, '0, '0);
      if (s_CORE_RST !== 1'b1 || s_DLDONE !== 1'b0 || s_DLERR !== 1'b1) badrun++;
    end
    checks++;
    if (badrun !== 0) begin errors++; $display("FAIL overrun_fail got %0d bad cycles want 0", badrun); end
  endtask

  task automatic test_skip();
    int badrun;
    tick(0, 0, '0, '0);
    tick(1, 0, '0, '0);
    tick(1, 1, 25'h0, 8'h11);
    checks++;
    if (s_ROMEN !== 1'b1 || s_ROMAD !== 25'h0 || s_DLERR !== 1'b0) begin
      errors++; $display("FAIL skip_first got romen %b ad %h err %b want 1 0 0", s_ROMEN, s_ROMAD, s_DLERR);
    end
    tick(1, 1, 25'h2, 8'h22);
    checks++;
    if (s_ROMEN !== 1'b1 || s_ROMAD !== 25'h2 || s_ROMDT !== 8'h22 || s_DLERR !== 1'b1 || s_CSUM !== 8'h33) begin
      errors++; $display("FAIL skip_second got romen %b ad %h dt %h err %b csum %h want 1 2 22 1 33",
        s_ROMEN, s_ROMAD, s_ROMDT, s_DLERR, s_CSUM);
    end
    tick(0, 0, '0, '0);
    badrun = 0;
    for (int i = 0; i < S_HOLD + 3; i++) begin
      tick(0, 0, '0, '0);
      if (s_CORE_RST !== 1'b1 || s_DLDONE !== 1'b0 || s_DLERR !== 1'b1) badrun++;
    end
    checks++;
    if (badrun !== 0) begin errors++; $display("FAIL skip_fail got %0d bad cycles want 0", badrun); end
  endtask

  task automatic test_toggle();
    int badrun;
    tick(1, 0, '0, '0);
    tick(0, 0, '0, '0);
    badrun = 0;
    for (int i = 0; i < S_HOLD + 3; i++) begin
      tick(0, 0, '0, '0);
      if (s_CORE_RST !== 1'b1 || s_DLDONE !== 1'b0 || s_DLERR !== 1'b0) badrun++;
    end
    checks++;
    if (badrun !== 0) begin errors++; $display("FAIL toggle_fail got %0d bad cycles want 0", badrun); end
  endtask

  task automatic test_region();
    logic [24:0] ra [5];
    logic [2:0]  rg [5];
    logic [24:0] a;
    ra = '{25'h0BFFF, 25'h0C000, 25'h17FFF, 25'h18000, 25'h2FFFF};
    rg = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    tick(0, 0, '0, '0);
    tick(1, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, ra[i], 8'(i));
      checks++;
      if (b_ROMEN !== 1'b1 || b_ROMAD !== ra[i] || b_REGION !== rg[i]) begin
        errors++; $display("FAIL region_tag got en %b ad %h rg %0d want 1 %h %0d", b_ROMEN, b_ROMAD, b_REGION, ra[i], rg[i]);
      end
      checks++;
      if (s_ROMEN !== 1'b0) begin errors++; $display("FAIL small_drop got %b want 0", s_ROMEN); end
    end
    for (int i = 0; i < 20; i++) begin
      a = 25'($urandom_range(32'h2FFFF));
      tick(1, 1, a, 8'($urandom));
      checks++;
      if (b_ROMEN !== 1'b1 || b_REGION !== ref_region(a)) begin
        errors++; $display("FAIL region_rand got en %b rg %0d want 1 %0d at %h", b_ROMEN, b_REGION, ref_region(a), a);
      end
    end
    checks++;
    if (s_DLERR !== 1'b1 || b_DLERR !== 1'b1) begin
      errors++; $display("FAIL region_err got %b %b want 1 1", s_DLERR, b_DLERR);
    end
    tick(0, 0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_good_load(1'b0, 1'b0);
    test_good_load(1'b1, 1'b1);
    test_outside_load();
    test_reload_reset();
    test_overrun();
    test_skip();
    test_toggle();
    test_region();
    test_good_load(1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
